// File: rtl/card7seg.sv
// Card-rank decoder: 4-bit card code to an active-low 7-segment glyph, plus a
// registered baccarat point value and card-present flag for the scoring logic.
module card7seg (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] SW,
    output logic [6:0] HEX0,
    output logic [3:0] card_value,
    output logic       card_valid
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [CODE_W-1:0] CODE_ACE  = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_NINE = CODE_W'(9);
    localparam logic [CODE_W-1:0] CODE_KING = CODE_W'(13);

    logic [CODE_W-1:0] card_value_q, card_value_d;
    logic              card_valid_q, card_valid_d;

    // Glyph lookup, segment order {g,f,e,d,c,b,a}, independent of clock and reset
    always_comb begin
        HEX0 = SEG_W'(7'b1111111);
        case (SW)
            4'd1:    HEX0 = SEG_W'(7'b0001000);
            4'd2:    HEX0 = SEG_W'(7'b0100100);
            4'd3:    HEX0 = SEG_W'(7'b0110000);
            4'd4:    HEX0 = SEG_W'(7'b0011001);
            4'd5:    HEX0 = SEG_W'(7'b0010010);
            4'd6:    HEX0 = SEG_W'(7'b0000010);
            4'd7:    HEX0 = SEG_W'(7'b1111000);
            4'd8:    HEX0 = SEG_W'(7'b0000000);
            4'd9:    HEX0 = SEG_W'(7'b0010000);
            4'd10:   HEX0 = SEG_W'(7'b1000000);
            4'd11:   HEX0 = SEG_W'(7'b1100001);
            4'd12:   HEX0 = SEG_W'(7'b0011000);
            4'd13:   HEX0 = SEG_W'(7'b0001001);
            default: HEX0 = SEG_W'(7'b1111111);
        endcase
    end

    // Pip cards score face value; tens, faces, empty and invalid codes score zero
    always_comb begin
        card_value_d = '0;
        card_valid_d = 1'b0;
        if (SW >= CODE_ACE && SW <= CODE_NINE) begin
            card_value_d = SW;
        end
        if (SW >= CODE_ACE && SW <= CODE_KING) begin
            card_valid_d = 1'b1;
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            card_value_q <= '0;
            card_valid_q <= 1'b0;
        end else begin
            card_value_q <= card_value_d;
            card_valid_q <= card_valid_d;
        end
    end

    assign card_value = card_value_q;
    assign card_valid = card_valid_q;

endmodule

// File: tb/tb_card7seg.sv
// Scoreboard bench for card7seg: driver queues expected register contents,
// a monitor pops and compares one cycle later; directed reset/latency checks.
module tb_card7seg;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] SW;
    logic [6:0] HEX0;
    logic [3:0] card_value;
    logic       card_valid;

    card7seg dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .SW         (SW),
        .HEX0       (HEX0),
        .card_value (card_value),
        .card_valid (card_valid)
    );

    typedef struct {
        int sw;
        int hex;
        int val;
        int vld;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] glyph[16];
    int         n_total = 0;
    int         n_pass  = 0;

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input int sw);
        exp_t e;
        e.sw  = sw;
        e.hex = int'(glyph[sw]);
        e.val = (sw >= 1 && sw <= 9) ? sw : 0;
        e.vld = (sw >= 1 && sw <= 13) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(input int sw);
        @(negedge slow_clock);
        SW = 4'(sw);
        sb.push_back(model(sw));
    endtask

    // Monitor: registers reflect the code presented before the latest edge
    initial begin
        exp_t e;
        forever begin
            @(posedge slow_clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("value sw=%0d", e.sw), int'(card_value), e.val);
                chk($sformatf("valid sw=%0d", e.sw), int'(card_valid), e.vld);
                chk($sformatf("hex sw=%0d", e.sw), int'(HEX0), e.hex);
            end
        end
    end

    initial begin
        int seq[9];
        int waited;
        glyph = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                  7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};
        seq = '{9, 10, 11, 12, 13, 0, 14, 15, 3};
        SW = 4'd0;
        resetb = 1'b1;
        #1 resetb = 1'b0;
        #1;
        chk("reset value", int'(card_value), 0);
        chk("reset valid", int'(card_valid), 0);

        // Display sweep while held in reset
        for (int i = 0; i < 16; i++) begin
            SW = 4'(i);
            #2;
            chk($sformatf("sweep hex sw=%0d", i), int'(HEX0), int'(glyph[i]));
        end
        SW = 4'd9;
        @(posedge slow_clock);
        #2;
        chk("held reset value", int'(card_value), 0);
        chk("held reset valid", int'(card_valid), 0);
        chk("held reset hex", int'(HEX0), 7'b0010000);

        @(negedge slow_clock);
        resetb = 1'b1;
        for (int i = 0; i < 9; i++) drive(seq[i]);
        for (int i = 0; i < 150; i++) drive(int'($urandom_range(0, 15)));
        drive(3);

        // Mid-cycle change: display follows at once, register waits for the edge
        @(negedge slow_clock);
        SW = 4'd5;
        #1;
        chk("latency hex", int'(HEX0), 7'b0010010);
        chk("latency value held", int'(card_value), 3);
        sb.push_back(model(5));

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge slow_clock);
            waited++;
        end
        chk("scoreboard drained", sb.size(), 0);

        @(negedge slow_clock);
        chk("pre-pulse value", int'(card_value), 5);
        #1 resetb = 1'b0;
        #1;
        chk("async reset value", int'(card_value), 0);
        chk("async reset valid", int'(card_valid), 0);
        chk("async reset hex", int'(HEX0), 7'b0010010);
        #1 resetb = 1'b1;
        @(posedge slow_clock);
        #2;
        chk("post-pulse value", int'(card_value), 5);
        chk("post-pulse valid", int'(card_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
